// File: rtl/risc_cycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RISC datapath.
// Ports: clk, rst (sync, active-high), run, instr_class, branch_taken in;
//   imem_re, ir_load, alu_en, dmem_re, dmem_we, reg_we, pc_en, pc_sel,
//   state, halted out.  Optional RISC_CTRL_PERF_EN adds instr_cnt, cycle_cnt.
module risc_cycle_ctrl #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned CLS_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CLS_W-1:0] instr_class,
  input  logic             branch_taken,
  output logic             imem_re,
  output logic             ir_load,
  output logic             alu_en,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             pc_en,
  output logic             pc_sel,
  output logic [2:0]       state,
  output logic             halted
`ifdef RISC_CTRL_PERF_EN
  ,
  output logic [31:0]      instr_cnt,
  output logic [31:0]      cycle_cnt
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;

  localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY - 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CLS_W-1:0] cls_q;

  logic is_alu, is_load, is_store;
  logic is_branch, is_halt;
  logic cnt_last, cnt_first;

  logic imem_re_c, ir_load_c, alu_en_c;
  logic dmem_re_c, dmem_we_c, reg_we_c;
  logic pc_en_c, pc_sel_c;

  assign is_alu    = (cls_q == CLS_W'(0));
  assign is_load   = (cls_q == CLS_W'(1));
  assign is_store  = (cls_q == CLS_W'(2));
  assign is_branch = (cls_q == CLS_W'(3));
  assign is_halt   = (cls_q == CLS_W'(4));

  assign cnt_last  = (cnt_q == LAST_CNT);
  assign cnt_first = (cnt_q == 3'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    imem_re_c = 1'b0;
    ir_load_c = 1'b0;
    alu_en_c  = 1'b0;
    dmem_re_c = 1'b0;
    dmem_we_c = 1'b0;
    reg_we_c  = 1'b0;
    pc_en_c   = 1'b0;
    pc_sel_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          cnt_d   = 3'd0;
        end
      end
      S_FETCH: begin
        imem_re_c = 1'b1;
        if (cnt_last) begin
          ir_load_c = 1'b1;
          state_d   = S_DECODE;
          cnt_d     = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        alu_en_c = 1'b1;
        cnt_d    = 3'd0;
        if (is_alu) begin
          state_d = S_WB;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_halt) begin
          state_d = S_HALTED;
        end else if (is_branch) begin
          pc_en_c  = 1'b1;
          pc_sel_c = branch_taken;
        end else begin
          pc_en_c = 1'b1;
        end
      end
      S_MEM: begin
        dmem_re_c = is_load;
        dmem_we_c = is_store && cnt_first;
        pc_en_c   = is_store && cnt_last;
        if (cnt_last) begin
          cnt_d = 3'd0;
          if (is_load) state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        pc_en_c  = 1'b1;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    // Every pc_en pulse marks the instruction boundary.
    if (pc_en_c) begin
      state_d = run ? S_FETCH : S_IDLE;
      cnt_d   = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE) cls_q <= instr_class;
    end
  end

  // Enables are masked while rst is high so a reset landing mid-instruction
  // never leaks a partial write or PC update.
  assign imem_re = imem_re_c & ~rst;
  assign ir_load = ir_load_c & ~rst;
  assign alu_en  = alu_en_c  & ~rst;
  assign dmem_re = dmem_re_c & ~rst;
  assign dmem_we = dmem_we_c & ~rst;
  assign reg_we  = reg_we_c  & ~rst;
  assign pc_en   = pc_en_c   & ~rst;
  assign pc_sel  = pc_sel_c  & ~rst;
  assign state   = state_q;
  assign halted  = (state_q == S_HALTED);

`ifdef RISC_CTRL_PERF_EN
  logic [31:0] instr_cnt_q, cycle_cnt_q;
  logic        busy;
  logic        retire;

  assign busy   = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign retire = pc_en_c || ((state_q == S_EXEC) && is_halt);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= 32'd0;
      cycle_cnt_q <= 32'd0;
    end else begin
      if (busy)   cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (retire) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_risc_cycle_ctrl.sv
// Self-checking bench for risc_cycle_ctrl: directed instruction walks
// plus randomized run/class/reset traffic against a cycle-index model.
module tb_risc_cycle_ctrl;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst, run, branch_taken;
  logic [2:0] instr_class;
  logic       imem_re, ir_load, alu_en, dmem_re;
  logic       dmem_we, reg_we, pc_en, pc_sel, halted;
  logic [2:0] state;
`ifdef RISC_CTRL_PERF_EN
  logic [31:0] instr_cnt, cycle_cnt;
`endif

  risc_cycle_ctrl #(.MEM_LATENCY(L), .CLS_W(3)) dut (
    .clk(clk), .rst(rst), .run(run),
    .instr_class(instr_class),
    .branch_taken(branch_taken),
    .imem_re(imem_re), .ir_load(ir_load),
    .alu_en(alu_en), .dmem_re(dmem_re),
    .dmem_we(dmem_we), .reg_we(reg_we),
    .pc_en(pc_en), .pc_sel(pc_sel),
    .state(state), .halted(halted)
`ifdef RISC_CTRL_PERF_EN
    , .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: mode 0 idle, 1 executing (k = cycles since FETCH entry), 2 halted.
  int m_mode, m_k, m_cls;
  bit [31:0] m_icnt, m_ccnt;
  int e_state;
  bit e_halt, e_imem, e_ir, e_alu, e_dre, e_dwe, e_reg, e_pc, e_sel;
  bit bnd;

  int o_state;
  bit o_halt, o_dre, o_dwe, o_reg, o_pc, o_sel, o_ir;

  int len, n_dre, n_dwe, n_reg, n_ir, sel_at_pc;
  int st_log[32];

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_eval(bit r, bit bt);
    e_state = 0;
    {e_halt, e_imem, e_ir, e_alu, e_dre} = '0;
    {e_dwe, e_reg, e_pc, e_sel} = '0;
    if (m_mode == 2) begin
      e_state = 6;
      e_halt  = 1;
    end else if (m_mode == 1) begin
      if (m_k < L) begin
        e_state = 1;
        e_imem  = 1;
        e_ir    = (m_k == L - 1);
      end else if (m_k == L) begin
        e_state = 2;
      end else if (m_k == L + 1) begin
        e_state = 3;
        e_alu   = 1;
        if (m_cls == 3) begin
          e_pc  = 1;
          e_sel = bt;
        end else if (m_cls >= 5) begin
          e_pc = 1;
        end
      end else if (m_cls == 0) begin
        e_state = 5;
        e_reg   = 1;
        e_pc    = 1;
      end else if (m_cls == 1) begin
        if (m_k < 2 * L + 2) begin
          e_state = 4;
          e_dre   = 1;
        end else begin
          e_state = 5;
          e_reg   = 1;
          e_pc    = 1;
        end
      end else begin
        e_state = 4;
        e_dwe   = (m_k == L + 2);
        e_pc    = (m_k == 2 * L + 1);
      end
    end
    bnd = e_pc;
    if (r) {e_imem, e_ir, e_alu, e_dre, e_dwe, e_reg, e_pc, e_sel} = '0;
  endtask

  task automatic tick(bit r, bit ru, int c, bit b);
    logic [12:0] act, exp;
    rst = r;
    run = ru;
    instr_class = 3'(c);
    branch_taken = b;
    #1;
    model_eval(r, b);
    act = {state, halted, imem_re, ir_load, alu_en, dmem_re,
           dmem_we, reg_we, pc_en, pc_sel};
    exp = {3'(e_state), e_halt, e_imem, e_ir, e_alu, e_dre,
           e_dwe, e_reg, e_pc, e_sel};
    chk("outputs", int'(act), int'(exp));
`ifdef RISC_CTRL_PERF_EN
    chk("instr_cnt", int'(instr_cnt), int'(m_icnt));
    chk("cycle_cnt", int'(cycle_cnt), int'(m_ccnt));
`endif
    o_state = int'(state);
    {o_halt, o_dre, o_dwe, o_reg, o_pc, o_sel, o_ir} =
      {halted, dmem_re, dmem_we, reg_we, pc_en, pc_sel, ir_load};
    if (r) begin
      m_mode = 0;
      m_k = 0;
      m_icnt = 0;
      m_ccnt = 0;
    end else if (m_mode == 0) begin
      if (ru) begin
        m_mode = 1;
        m_k = 0;
      end
    end else if (m_mode == 1) begin
      m_ccnt++;
      if (m_k == L) m_cls = c;
      if (m_k == L + 1 && m_cls == 4) begin
        m_mode = 2;
        m_icnt++;
      end else if (bnd) begin
        m_icnt++;
        m_k = 0;
        if (!ru) m_mode = 0;
      end else begin
        m_k++;
      end
    end
    @(negedge clk);
  endtask

  // Runs one instruction from FETCH entry to its boundary (or HALTED).
  task automatic run_instr(int c, bit b);
    bit done = 0;
    len = 0; n_dre = 0; n_dwe = 0; n_reg = 0; n_ir = 0;
    sel_at_pc = -1;
    for (int i = 0; i < 30 && !done; i++) begin
      tick(0, 1, c, b);
      st_log[len] = o_state;
      len++;
      n_dre += int'(o_dre);
      n_dwe += int'(o_dwe);
      n_reg += int'(o_reg);
      n_ir  += int'(o_ir);
      if (o_pc) sel_at_pc = int'(o_sel);
      if (o_pc || o_halt) done = 1;
    end
    chk("instr_timeout", int'(done), 1);
  endtask

  task automatic tick_until_state(int s, int c);
    bit hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick(0, 1, c, 0);
      if (o_state == s) hit = 1;
    end
    chk("reach_state_timeout", int'(hit), 1);
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
  endtask

  int exp_alu[5] = '{1, 1, 2, 3, 5};

  initial begin
    m_mode = 0; m_k = 0; m_cls = 0;
    m_icnt = 0; m_ccnt = 0;
    rst = 1; run = 0; instr_class = 0; branch_taken = 0;
    @(negedge clk);
    do_reset();
    tick(0, 1, 0, 0);
    chk("reset_state", o_state, 0);

    run_instr(0, 0);
    chk("alu_len", len, 5);
    for (int i = 0; i < 5; i++) chk("alu_state_seq", st_log[i], exp_alu[i]);
    chk("alu_ir_load", n_ir, 1);
    chk("alu_reg_we", n_reg, 1);

    run_instr(1, 0);
    chk("load_len", len, 7);
    chk("load_dmem_re", n_dre, 2);
    chk("load_reg_we", n_reg, 1);

    run_instr(2, 0);
    chk("store_len", len, 6);
    chk("store_dmem_we", n_dwe, 1);
    chk("store_reg_we", n_reg, 0);
    chk("store_pc_state", st_log[5], 4);

    run_instr(3, 1);
    chk("br_t_len", len, 4);
    chk("br_t_sel", sel_at_pc, 1);
    run_instr(3, 0);
    chk("br_n_len", len, 4);
    chk("br_n_sel", sel_at_pc, 0);
    run_instr(6, 1);
    chk("nop_len", len, 4);
    chk("nop_sel", sel_at_pc, 0);

    run_instr(4, 0);
    chk("halt_state", o_state, 6);
    for (int i = 0; i < 20; i++) tick(0, i[0], 0, 0);
    chk("halt_sticky", o_state, 6);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("halt_rst_state", o_state, 0);
    chk("halt_rst_halted", int'(o_halt), 0);

    tick(0, 1, 1, 0);
    tick_until_state(4, 1);
    begin
      bit hit = 0;
      for (int i = 0; i < 10 && !hit; i++) begin
        tick(0, 0, 1, 0);
        if (o_pc) hit = 1;
      end
      chk("drop_boundary_seen", int'(hit), 1);
    end
    chk("drop_wb_state", o_state, 5);
    tick(0, 0, 0, 0);
    chk("drop_idle", o_state, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    chk("resume_fetch", o_state, 1);

    tick_until_state(4, 1);
    tick(1, 1, 1, 0);
    chk("rst_mem_dre", int'(o_dre), 0);
    tick(0, 0, 0, 0);
    chk("rst_mem_state", o_state, 0);

`ifdef RISC_CTRL_PERF_EN
    do_reset();
    tick(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) run_instr(0, 0);
    run_instr(4, 0);
    chk("perf_instr", int'(instr_cnt), 4);
    chk("perf_cycle", int'(cycle_cnt), 19);
`endif

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom % 60) == 0, ($urandom % 8) != 0,
           int'($urandom % 8), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
